// File: rtl/calc_pkg.sv
// Shared definitions for the result path between the operations stage and
// the seven-segment display: FSM state type, result sizing and display codes.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int RES_WIDTH   = 14;
  localparam int NUM_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;

  // Code the display stage renders as a minus sign.
  localparam logic [3:0] BCD_MINUS = 4'hA;

  // 10^n, used to size the largest value the digits can show.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: a nibble of 5 or more gets 3 added so
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add-3 correction; only 5..9 occur in a valid nibble, so no carry out.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Display outputs are updated only in LOAD, so the digit decoders never see
// partial shift-register contents.
//
// Handshake: start is a request that is honoured only when the FSM is in
// IDLE; a start seen while busy=1 is dropped, never queued. done is a single
// cycle pulse, coincident with the new bcd/neg_out/overflow/lead_zero values,
// which then hold until the next done.
module bcd_result_converter
  import calc_pkg::*;
#(
  parameter int WIDTH  = RES_WIDTH,
  parameter int DIGITS = NUM_DIGITS,
  parameter int AUTO   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  neg_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lead_zero,
  output state_t                dbg_state
);

  localparam int SRW = DIGITS * 4 + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = 64'(pow10(DIGITS) - 1);
  localparam logic [DIGITS-1:0] LZ_RST = ~(DIGITS'(1));

  state_t               state_q;
  state_t               state_d;
  logic                 accept;
  logic [SRW-1:0]       sr_q;
  logic [SRW-1:0]       sr_adj;
  logic [SRW-1:0]       sr_shift;
  logic [4*DIGITS-1:0]  adj_digits;
  logic [4*DIGITS-1:0]  final_digits;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     bin_q;
  logic                 neg_q;
  logic [WIDTH:0]       last_q;
  logic [DIGITS-1:0]    lz_calc;
  logic                 all_zero;
  logic                 ovf_calc;
  logic                 is_zero;

  assign dbg_state = state_q;

  // Per-digit add-3 cells on the BCD part of the shift register.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr_q[WIDTH + 4*k +: 4]),
      .dout (adj_digits[4*k +: 4])
    );
  end

  // Corrected register shifted left by one: the next SHIFT-state value.
  always_comb begin
    sr_adj   = {adj_digits, sr_q[WIDTH-1:0]};
    sr_shift = sr_adj << 1;
  end

  assign final_digits = sr_q[SRW-1 -: 4*DIGITS];
  assign ovf_calc     = 64'(bin_q) > MAX_VAL;
  assign is_zero      = (bin_q == '0);

  // Leading-zero flags: digit k is blank when it and every higher digit is 0.
  always_comb begin
    lz_calc  = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (final_digits[4*k +: 4] == 4'd0);
      lz_calc[k] = all_zero;
    end
  end

  // Next-state logic; accept marks the edge that launches a conversion.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || ((AUTO != 0) && ({bin, neg_in} != last_q))) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch on accept, shift in SHIFT, publish results in LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      bin_q     <= '0;
      neg_q     <= 1'b0;
      last_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      neg_out   <= 1'b0;
      overflow  <= 1'b0;
      lead_zero <= LZ_RST;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            bin_q <= bin;
            neg_q <= neg_in;
            sr_q  <= {{(4*DIGITS){1'b0}}, bin};
            cnt_q <= CW'(WIDTH);
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          sr_q  <= sr_shift;
          cnt_q <= cnt_q - CW'(1);
        end
        LOAD: begin
          if (ovf_calc) begin
            bcd       <= {DIGITS{4'h9}};
            neg_out   <= neg_q;
            overflow  <= 1'b1;
            lead_zero <= '0;
          end else begin
            bcd       <= final_digits;
            neg_out   <= neg_q & ~is_zero;
            overflow  <= 1'b0;
            lead_zero <= lz_calc;
          end
          done   <= 1'b1;
          busy   <= 1'b0;
          last_q <= {bin_q, neg_q};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_result_converter.sv
// Bench for bcd_result_converter: one AUTO=1 and one AUTO=0 instance share
// the inputs; a transaction-level model predicts every output each cycle.
module tb_bcd_result_converter;
  import calc_pkg::*;

  localparam int W = 14;
  localparam int LAT = W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [W-1:0]  bin;
  logic          neg_in;

  logic          busy_a, done_a, neg_a, ovf_a;
  logic [15:0]   bcd_a;
  logic [3:0]    lz_a;
  state_t        st_a;
  logic          busy_m, done_m, neg_m, ovf_m;
  logic [15:0]   bcd_m;
  logic [3:0]    lz_m;
  state_t        st_m;

  int n_checks = 0;
  int n_errors = 0;

  bcd_result_converter #(.WIDTH(W), .DIGITS(4), .AUTO(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .neg_in(neg_in),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .neg_out(neg_a),
    .overflow(ovf_a), .lead_zero(lz_a), .dbg_state(st_a)
  );

  bcd_result_converter #(.WIDTH(W), .DIGITS(4), .AUTO(0)) dut_m (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .neg_in(neg_in),
    .busy(busy_m), .done(done_m), .bcd(bcd_m), .neg_out(neg_m),
    .overflow(ovf_m), .lead_zero(lz_m), .dbg_state(st_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models the AUTO=1 instance, index 1 the AUTO=0 instance.
  int           rem[2];
  int           lval[2];
  logic         lneg[2];
  logic [W:0]   last[2];
  logic         e_busy[2], e_done[2], e_neg[2], e_ovf[2];
  logic [15:0]  e_bcd[2];
  logic [3:0]   e_lz[2];

  function automatic logic [15:0] exp_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [3:0] exp_lz(input int v);
    logic [3:0] r;
    r[0] = 1'b0;
    r[1] = (v < 10);
    r[2] = (v < 100);
    r[3] = (v < 1000);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        rem[i] = 0; last[i] = '0; lval[i] = 0; lneg[i] = 1'b0;
        e_busy[i] = 1'b0; e_done[i] = 1'b0; e_neg[i] = 1'b0;
        e_ovf[i] = 1'b0; e_bcd[i] = 16'h0; e_lz[i] = 4'b1110;
      end else begin
        e_done[i] = 1'b0;
        if (rem[i] == 0) begin
          if (start || (i == 0 && {bin, neg_in} != last[i])) begin
            rem[i] = LAT; lval[i] = int'(bin); lneg[i] = neg_in;
            e_busy[i] = 1'b1;
          end
        end else begin
          rem[i]--;
          if (rem[i] == 0) begin
            e_bcd[i]  = exp_bcd(lval[i]);
            e_ovf[i]  = (lval[i] > 9999);
            e_lz[i]   = e_ovf[i] ? 4'b0000 : exp_lz(lval[i]);
            e_neg[i]  = (lval[i] == 0) ? 1'b0 : lneg[i];
            e_done[i] = 1'b1;
            e_busy[i] = 1'b0;
            last[i]   = {W'(lval[i]), lneg[i]};
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("a_busy", busy_a, e_busy[0]);
    check("a_done", done_a, e_done[0]);
    check("a_bcd",  bcd_a,  e_bcd[0]);
    check("a_neg",  neg_a,  e_neg[0]);
    check("a_ovf",  ovf_a,  e_ovf[0]);
    check("a_lz",   lz_a,   e_lz[0]);
    check("m_busy", busy_m, e_busy[1]);
    check("m_done", done_m, e_done[1]);
    check("m_bcd",  bcd_m,  e_bcd[1]);
    check("m_neg",  neg_m,  e_neg[1]);
    check("m_ovf",  ovf_m,  e_ovf[1]);
    check("m_lz",   lz_m,   e_lz[1]);
  end

  // ---------------- driver tasks ----------------
  // Drive one request and wait for done on the AUTO=1 instance; lat counts
  // clock edges after the edge that accepted the request.
  task automatic run(input logic [W-1:0] b, input logic n, input bit use_start, output int lat);
    @(negedge clk);
    bin = b; neg_in = n; start = use_start;
    lat = -1;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (done_a) break;
      check("busy_while_conv", busy_a, 1'b1);
      if (lat > 40) begin
        n_checks++; n_errors++;
        $display("FAIL done_timeout: got no done, expected done after %0d edges", LAT);
        break;
      end
    end
    check("busy_on_done", busy_a, 1'b0);
  endtask

  int lat;
  int dones_a, dones_m;
  logic [15:0] cap_a, cap_m;
  logic busy_m_at_restart;

  initial begin
    rst = 1'b0; start = 1'b0; bin = '0; neg_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_bcd",  bcd_a,  16'h0000);
    check("rst_lz",   lz_a,   4'b1110);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // zero with negative sign: no "-0"
    run(14'd0, 1'b1, 1'b1, lat);
    check("zero_lat", lat, 15);
    check("zero_bcd", bcd_a, 16'h0000);
    check("zero_neg", neg_a, 1'b0);
    check("zero_lz",  lz_a,  4'b1110);
    check("zero_ovf", ovf_a, 1'b0);

    run(14'd9999, 1'b0, 1'b1, lat);
    check("max_lat", lat, 15);
    check("max_bcd", bcd_a, 16'h9999);
    check("max_lz",  lz_a,  4'b0000);
    check("max_ovf", ovf_a, 1'b0);

    run(14'd1234, 1'b1, 1'b1, lat);
    check("v1234_bcd", bcd_a, 16'h1234);
    check("v1234_neg", neg_a, 1'b1);
    run(14'd56, 1'b1, 1'b1, lat);
    check("v56_bcd", bcd_a, 16'h0056);
    check("v56_lz",  lz_a,  4'b1100);

    run(14'd12000, 1'b0, 1'b1, lat);
    check("ovf_flag", ovf_a, 1'b1);
    check("ovf_bcd",  bcd_a, 16'h9999);
    check("ovf_lz",   lz_a,  4'b0000);
    run(14'd42, 1'b0, 1'b1, lat);
    check("v42_ovf", ovf_a, 1'b0);
    check("v42_bcd", bcd_a, 16'h0042);

    // start during SHIFT with a new value: dropped by both, AUTO picks it up
    dones_a = 0; dones_m = 0; cap_a = '0; cap_m = '0; busy_m_at_restart = 1'b0;
    @(negedge clk);
    bin = 14'd100; neg_in = 1'b0; start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 4) begin bin = 14'd200; start = 1'b1; end
      if (c == 5) begin start = 1'b0; busy_m_at_restart = busy_m; end
      if (done_a) begin dones_a++; cap_a = bcd_a; end
      if (done_m) begin dones_m++; cap_m = bcd_m; end
    end
    check("manual_busy_at_start", busy_m_at_restart, 1'b1);
    check("manual_dones", dones_m, 1);
    check("manual_bcd", cap_m, 16'h0100);
    check("auto_dones", dones_a, 2);
    check("auto_bcd", cap_a, 16'h0200);

    // asynchronous reset mid-conversion, then AUTO retrigger of 777
    @(negedge clk);
    bin = 14'd777; neg_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_bcd",  bcd_a,  16'h0000);
    check("abort_lz",   lz_a,   4'b1110);
    check("abort_state", st_a, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    lat = -1;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done_a) break;
      if (lat > 40) begin
        n_checks++; n_errors++;
        $display("FAIL retrigger_timeout: got no done, expected done after %0d edges", LAT);
        break;
      end
    end
    check("retrig_lat", lat, 15);
    check("retrig_bcd", bcd_a, 16'h0777);

    // randomized traffic checked every cycle by the scoreboard
    for (int it = 0; it < 150; it++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: bin = W'($urandom_range(0, 99));
        1: bin = W'($urandom_range(0, 9999));
        2: bin = W'($urandom_range(9990, 10010));
        default: bin = W'($urandom_range(0, 16383));
      endcase
      neg_in = 1'($urandom_range(0, 1));
      start  = ($urandom_range(0, 2) == 0);
      for (int h = 0; h < int'($urandom_range(1, 20)); h++) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
